// File: rtl/sysarr_pkg.sv
// Shared types and defaults for the systolic-array input skewer.
package sysarr_pkg;

  localparam int SKEW_N_DEF  = 4;
  localparam int SKEW_DW_DEF = 8;
  localparam int VEC_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } skew_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// One lane of the skewer: a DEPTH-stage shift line of {active, data}.
// Build option SKEW_BUBBLE_ZERO_EN: bubbles carry zero data instead of holding the last element.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_active,
  input  logic [DW-1:0] in_data,
  output logic          out_active,
  output logic [DW-1:0] out_data
);

  logic [DEPTH-1:0]         act_q, act_d;
  logic [DEPTH-1:0][DW-1:0] dat_q, dat_d;

  always_comb begin
    act_d    = act_q;
    dat_d    = dat_q;
    act_d[0] = in_active;
`ifdef SKEW_BUBBLE_ZERO_EN
    dat_d[0] = in_active ? in_data : '0;
`else
    // Holding stage 0 means inactive lane output shows the last valid element.
    dat_d[0] = in_active ? in_data : dat_q[0];
`endif
    for (int i = 1; i < DEPTH; i++) begin
      act_d[i] = act_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_q <= '0;
      dat_q <= '0;
    end else begin
      act_q <= act_d;
      dat_q <= dat_d;
    end
  end

  assign out_active = act_q[DEPTH-1];
  assign out_data   = dat_q[DEPTH-1];

endmodule

// File: rtl/sysarr_input_skewer.sv
// Left-edge feeder for the systolic array: lane r is delayed r cycles, batch FSM flags completion.
// Build option SKEW_BUBBLE_ZERO_EN (see skew_delay_line) selects zeroed bubble data.
module sysarr_input_skewer
  import sysarr_pkg::*;
#(
  parameter int N  = SKEW_N_DEF,
  parameter int DW = SKEW_DW_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DW-1:0]      in_data,
  input  logic                 in_last,
  output logic [N*DW-1:0]      out_data,
  output logic [N-1:0]         out_active,
  output logic                 busy,
  output logic                 done,
  output logic [VEC_CNT_W-1:0] vec_count
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  skew_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [VEC_CNT_W-1:0] vec_count_q, vec_count_d;
  logic                 hs;

  assign hs = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_count_q <= vec_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_count_d = vec_count_q;
    if (hs && (vec_count_q != '1)) vec_count_d = vec_count_q + 1'b1;
    case (state_q)
      IDLE, STREAM: begin
        if (hs) begin
          if (!in_last) begin
            state_d = STREAM;
          end else if (N == 1) begin
            state_d = DONE;
          end else begin
            // Last vector still needs N-1 edges to reach the bottom lane.
            state_d = DRAIN;
            cnt_d   = CNT_W'(N - 1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(1)) state_d = DONE;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        state_d     = IDLE;
        vec_count_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE) || (state_q == STREAM);
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
  end

  assign vec_count = vec_count_q;

  for (genvar r = 0; r < N; r++) begin : g_lane
    skew_delay_line #(
      .DEPTH (r + 1),
      .DW    (DW)
    ) u_dl (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_active  (hs),
      .in_data    (in_data[r*DW +: DW]),
      .out_active (out_active[r]),
      .out_data   (out_data[r*DW +: DW])
    );
  end

endmodule

// File: tb/tb_sysarr_input_skewer.sv
// Scoreboard bench for sysarr_input_skewer (N=4): driver queues per-lane and done expectations, negedge monitor checks.
module tb_sysarr_input_skewer;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic            in_ready, busy, done;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_active;
  logic [15:0]     vec_count;

  sysarr_input_skewer #(.N(N), .DW(DW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_data   (out_data),
    .out_active (out_active),
    .busy       (busy),
    .done       (done),
    .vec_count  (vec_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    int            e;
  } lx_t;

  lx_t           lq[N][$];
  int            dq_e[$];
  int            dq_cnt[$];
  logic [DW-1:0] last_val[N];
  int            batch_n = 0;
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bad(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic flush();
    for (int r = 0; r < N; r++) begin
      lq[r].delete();
      last_val[r] = '0;
    end
    dq_e.delete();
    dq_cnt.delete();
    batch_n = 0;
  endtask

  task automatic send(input logic [31:0] v, input logic last);
    int w;
    int k;
    lx_t x;
    w        = 0;
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    if (!in_ready) begin
      bad("send_timeout");
    end else begin
      k = cyc + 1;
      for (int r = 0; r < N; r++) begin
        x.d = v[r*DW +: DW];
        x.e = k + r;
        lq[r].push_back(x);
      end
      batch_n++;
      if (last) begin
        dq_e.push_back(k + N - 1);
        dq_cnt.push_back(batch_n);
        batch_n = 0;
      end
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: pops expectations whenever a lane is active or done pulses.
  lx_t mx;
  always @(negedge clock) begin
    for (int r = 0; r < N; r++) begin
      if (out_active[r]) begin
        if (lq[r].size() == 0) begin
          bad($sformatf("unexpected_active_lane%0d data %0h", r, out_data[r*DW +: DW]));
        end else begin
          mx = lq[r].pop_front();
          chk($sformatf("lane%0d_data", r), 32'(out_data[r*DW +: DW]), 32'(mx.d));
          chk($sformatf("lane%0d_edge", r), cyc, mx.e);
          last_val[r] = mx.d;
        end
      end else begin
        if (lq[r].size() != 0 && lq[r][0].e <= cyc) begin
          bad($sformatf("missing_active_lane%0d expected_edge %0d", r, lq[r][0].e));
          mx = lq[r].pop_front();
        end
`ifdef SKEW_BUBBLE_ZERO_EN
        chk($sformatf("bubble_lane%0d", r), 32'(out_data[r*DW +: DW]), 32'h0);
`else
        chk($sformatf("bubble_lane%0d", r), 32'(out_data[r*DW +: DW]), 32'(last_val[r]));
`endif
      end
    end
    if (done) begin
      if (dq_e.size() == 0) begin
        bad("unexpected_done");
      end else begin
        chk("done_edge", cyc, dq_e.pop_front());
        chk("done_vec_count", 32'(vec_count), dq_cnt.pop_front());
      end
    end else if (dq_e.size() != 0 && dq_e[0] < cyc) begin
      bad($sformatf("missing_done expected_edge %0d", dq_e[0]));
      void'(dq_e.pop_front());
      void'(dq_cnt.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < N; r++) last_val[r] = '0;
    #1;
    chk("rst_out_active", 32'(out_active), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_vec_count", 32'(vec_count), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Single-vector batch from IDLE.
    send(pk(8'd1, 8'd2, 8'd3, 8'd4), 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("s1_ready_low", 32'(in_ready), 32'h0);
      chk("s1_busy", 32'(busy), 32'h1);
      step();
    end
    chk("s1_ready_back", 32'(in_ready), 32'h1);
    chk("s1_vc_clear", 32'(vec_count), 32'h0);

    // Three back-to-back vectors.
    send(pk(8'h10, 8'h20, 8'h30, 8'h40), 1'b0);
    send(pk(8'h11, 8'h21, 8'h31, 8'h41), 1'b0);
    send(pk(8'h12, 8'h22, 8'h32, 8'h42), 1'b1);
    chk("s2_vec_count", 32'(vec_count), 32'h3);
    repeat (4) step();
    chk("s2_vc_clear", 32'(vec_count), 32'h0);

    // Gap between two vectors.
    send(pk(8'hA0, 8'hA1, 8'hA2, 8'hA3), 1'b0);
    step();
    send(pk(8'hB0, 8'hB1, 8'hB2, 8'hB3), 1'b1);
    repeat (4) step();

    // Valid offered during drain must be ignored.
    send(pk(8'h11, 8'h22, 8'h33, 8'h44), 1'b1);
    in_valid = 1'b1;
    in_data  = {N{8'h7F}};
    for (int i = 0; i < 3; i++) begin
      chk("s4_not_ready", 32'(in_ready), 32'h0);
      chk("s4_vc_hold", 32'(vec_count), 32'h1);
      step();
    end
    in_valid = 1'b0;
    chk("s4_done", 32'(done), 32'h1);
    chk("s4_vc_at_done", 32'(vec_count), 32'h1);
    step();
    chk("s4_vc_clear", 32'(vec_count), 32'h0);
    chk("s4_ready_back", 32'(in_ready), 32'h1);

    // Reset mid-batch discards everything, no done afterwards.
    send(pk(8'h5A, 8'h6B, 8'h7C, 8'h0D), 1'b1);
    step();
    step();
    reset_n = 1'b0;
    flush();
    #1;
    chk("s5_out_active", 32'(out_active), 32'h0);
    chk("s5_out_data", out_data, 32'h0);
    chk("s5_busy", 32'(busy), 32'h0);
    chk("s5_done", 32'(done), 32'h0);
    chk("s5_vec_count", 32'(vec_count), 32'h0);
    chk("s5_in_ready", 32'(in_ready), 32'h1);
    step();
    step();
    reset_n = 1'b1;
    repeat (8) step();
    chk("s5_idle_busy", 32'(busy), 32'h0);

    // Signed extremes pass through bit-exact.
    send(pk(8'h80, 8'h7F, 8'hFF, 8'h00), 1'b1);
    repeat (6) step();

    for (int r = 0; r < N; r++) chk($sformatf("lane%0d_queue_drained", r), lq[r].size(), 0);
    chk("done_queue_drained", dq_e.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
